// File: rtl/data_mem_access.sv
// Memory-stage load/store access unit: one word-aligned bus transaction per legal
// request, pipeline stall until the bus responds, registered raw load result and error reporting.
module data_mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ReqValid,
    input  logic [2:0]  LoadType,
    input  logic [1:0]  StoreType,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    output logic        BusReq,
    output logic        BusWe,
    output logic [31:0] BusAddr,
    output logic [31:0] BusWdata,
    output logic [3:0]  BusByteEn,
    input  logic [31:0] BusRdata,
    input  logic        BusReady,
    output logic        Stall,
    output logic [31:0] RdataOut,
    output logic [1:0]  LoadedBytesSelect,
    output logic [2:0]  RegWriteOut,
    output logic        Err,
    output logic [1:0]  ErrCause,
    output logic [31:0] ErrAddr
);

    localparam logic [2:0] NOREGWRITE = 3'd0;
    localparam logic [2:0] LB         = 3'd1;
    localparam logic [2:0] LH         = 3'd2;
    localparam logic [2:0] LW         = 3'd3;
    localparam logic [2:0] LBU        = 3'd4;
    localparam logic [2:0] LHU        = 3'd5;

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_SB   = 2'b01;
    localparam logic [1:0] ST_SH   = 2'b10;
    localparam logic [1:0] ST_SW   = 2'b11;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_BOTH     = 2'b11;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] st, input logic [1:0] off);
        case (st)
            ST_SB:   lane_mask = 4'b0001 << off;
            ST_SH:   lane_mask = 4'b0011 << off;
            ST_SW:   lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] st, input logic [31:0] d);
        case (st)
            ST_SB:   lane_data = {4{d[7:0]}};
            ST_SH:   lane_data = {2{d[15:0]}};
            ST_SW:   lane_data = d;
            default: lane_data = 32'd0;
        endcase
    endfunction

    // Byte accesses are always aligned; halfwords need an even address, words a multiple of four.
    function automatic logic misaligned(input logic [2:0] lt, input logic [1:0] st,
                                        input logic [1:0] off);
        if (st != ST_NONE) begin
            case (st)
                ST_SH:   misaligned = off[0];
                ST_SW:   misaligned = |off;
                default: misaligned = 1'b0;
            endcase
        end else begin
            case (lt)
                LH, LHU: misaligned = off[0];
                LW:      misaligned = |off;
                LB, LBU: misaligned = 1'b0;
                default: misaligned = 1'b0;
            endcase
        end
    endfunction

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [2:0]  load_type_q, load_type_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  lbs_q, lbs_d;
    logic [2:0]  reg_write_q, reg_write_d;
    logic        err_q, err_d;
    logic [1:0]  err_cause_q, err_cause_d;
    logic [31:0] err_addr_q, err_addr_d;

    logic is_load_s;
    logic is_store_s;
    logic access_s;
    logic both_s;
    logic legal_s;
    logic timeout_hit_s;

    assign is_load_s     = (LoadType != NOREGWRITE);
    assign is_store_s    = (StoreType != ST_NONE);
    assign access_s      = ReqValid && (is_load_s || is_store_s);
    assign both_s        = is_load_s && is_store_s;
    assign legal_s       = access_s && !both_s && !misaligned(LoadType, StoreType, Addr[1:0]);
    assign timeout_hit_s = (state_q == WAIT) && !BusReady && (cnt_q == TIMEOUT_LAST);

    assign Stall = !rst && (((state_q == IDLE) && legal_s) ||
                            ((state_q == WAIT) && !BusReady && !timeout_hit_s));

    // Next-state, bus launch/teardown, load result capture and error reporting.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        load_type_d = load_type_q;
        off_d       = off_q;
        req_addr_d  = req_addr_q;
        rdata_d     = rdata_q;
        lbs_d       = lbs_q;
        reg_write_d = NOREGWRITE;
        err_d       = 1'b0;
        err_cause_d = err_cause_q;
        err_addr_d  = err_addr_q;

        case (state_q)
            IDLE: begin
                if (legal_s) begin
                    state_d     = WAIT;
                    cnt_d       = 16'd0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = is_store_s;
                    bus_addr_d  = {Addr[31:2], 2'b00};
                    bus_wdata_d = lane_data(StoreType, StoreData);
                    bus_be_d    = lane_mask(StoreType, Addr[1:0]);
                    load_type_d = LoadType;
                    off_d       = Addr[1:0];
                    req_addr_d  = Addr;
                end else if (access_s) begin
                    err_d       = 1'b1;
                    err_cause_d = both_s ? CAUSE_BOTH : CAUSE_MISALIGN;
                    err_addr_d  = Addr;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (BusReady || timeout_hit_s) begin
                    state_d     = IDLE;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = 32'd0;
                    bus_wdata_d = 32'd0;
                    bus_be_d    = 4'b0000;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end

                if (BusReady && !bus_we_q) begin
                    reg_write_d = load_type_q;
                    rdata_d     = BusRdata;
                    lbs_d       = off_q;
                end else if (timeout_hit_s) begin
                    err_d       = 1'b1;
                    err_cause_d = CAUSE_TIMEOUT;
                    err_addr_d  = req_addr_q;
                end else begin
                    reg_write_d = NOREGWRITE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_be_q    <= 4'b0000;
            load_type_q <= NOREGWRITE;
            off_q       <= 2'b00;
            req_addr_q  <= 32'd0;
            rdata_q     <= 32'd0;
            lbs_q       <= 2'b00;
            reg_write_q <= NOREGWRITE;
            err_q       <= 1'b0;
            err_cause_q <= 2'b00;
            err_addr_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            load_type_q <= load_type_d;
            off_q       <= off_d;
            req_addr_q  <= req_addr_d;
            rdata_q     <= rdata_d;
            lbs_q       <= lbs_d;
            reg_write_q <= reg_write_d;
            err_q       <= err_d;
            err_cause_q <= err_cause_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign BusReq            = bus_req_q;
    assign BusWe             = bus_we_q;
    assign BusAddr           = bus_addr_q;
    assign BusWdata          = bus_wdata_q;
    assign BusByteEn         = bus_be_q;
    assign RdataOut          = rdata_q;
    assign LoadedBytesSelect = lbs_q;
    assign RegWriteOut       = reg_write_q;
    assign Err               = err_q;
    assign ErrCause          = err_cause_q;
    assign ErrAddr           = err_addr_q;

endmodule

// File: tb/tb_data_mem_access.sv
// Bench for data_mem_access: directed vector table, hand-written multi-cycle sequences
// and random accesses checked against a size/offset arithmetic reference model.
module tb_data_mem_access;

    localparam int TMO = 4;

    localparam logic [2:0] NOREGWRITE = 3'd0;
    localparam logic [2:0] LB         = 3'd1;
    localparam logic [2:0] LH         = 3'd2;
    localparam logic [2:0] LW         = 3'd3;
    localparam logic [2:0] LBU        = 3'd4;
    localparam logic [2:0] LHU        = 3'd5;

    typedef struct {
        logic [2:0]  lt;
        logic [1:0]  st;
        logic [31:0] addr;
        logic [31:0] data;
        int          waits;
        logic [31:0] rdata;
        logic        exp_legal;
        logic [1:0]  exp_cause;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ReqValid;
    logic [2:0]  LoadType;
    logic [1:0]  StoreType;
    logic [31:0] Addr;
    logic [31:0] StoreData;
    logic        BusReq;
    logic        BusWe;
    logic [31:0] BusAddr;
    logic [31:0] BusWdata;
    logic [3:0]  BusByteEn;
    logic [31:0] BusRdata;
    logic        BusReady;
    logic        Stall;
    logic [31:0] RdataOut;
    logic [1:0]  LoadedBytesSelect;
    logic [2:0]  RegWriteOut;
    logic        Err;
    logic [1:0]  ErrCause;
    logic [31:0] ErrAddr;

    int total = 0;
    int bad   = 0;

    data_mem_access #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .ReqValid(ReqValid), .LoadType(LoadType),
        .StoreType(StoreType), .Addr(Addr), .StoreData(StoreData),
        .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr), .BusWdata(BusWdata),
        .BusByteEn(BusByteEn), .BusRdata(BusRdata), .BusReady(BusReady),
        .Stall(Stall), .RdataOut(RdataOut), .LoadedBytesSelect(LoadedBytesSelect),
        .RegWriteOut(RegWriteOut), .Err(Err), .ErrCause(ErrCause), .ErrAddr(ErrAddr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: access size from the opcode, legality by modulo, lanes by arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        bit   ld;
        bit   stv;
        int   size;
        r = v;
        ld  = (v.lt != NOREGWRITE);
        stv = (v.st != 2'b00);
        r.exp_legal = 1'b0;
        r.exp_cause = 2'b00;
        r.exp_be    = 4'b0000;
        r.exp_wdata = 32'd0;
        if (stv) size = (v.st == 2'b01) ? 1 : (v.st == 2'b10) ? 2 : 4;
        else     size = (v.lt == LB || v.lt == LBU) ? 1 : (v.lt == LH || v.lt == LHU) ? 2 : 4;
        if (ld && stv) begin
            r.exp_cause = 2'b11;
        end else if (ld || stv) begin
            if ((v.addr % 32'(size)) != 32'd0) begin
                r.exp_cause = 2'b01;
            end else begin
                r.exp_legal = 1'b1;
                if (stv) begin
                    r.exp_be = 4'(((1 << size) - 1) << (v.addr % 32'd4));
                    if (size == 1)      r.exp_wdata = (v.data & 32'hFF) * 32'h01010101;
                    else if (size == 2) r.exp_wdata = (v.data & 32'hFFFF) * 32'h00010001;
                    else                r.exp_wdata = v.data;
                end
            end
        end
        return r;
    endfunction

    task automatic idle_inputs();
        ReqValid  = 1'b0;
        LoadType  = NOREGWRITE;
        StoreType = 2'b00;
        BusReady  = 1'b0;
    endtask

    task automatic run_access(input vec_t v);
        bit ld;
        bit stv;
        bit timed_out;
        int n;
        ld  = (v.lt != NOREGWRITE);
        stv = (v.st != 2'b00);
        @(posedge clk); #1;
        ReqValid = 1'b1; LoadType = v.lt; StoreType = v.st;
        Addr = v.addr; StoreData = v.data; BusReady = 1'b0; BusRdata = v.rdata;
        @(negedge clk);
        chk("accept_stall", 32'(Stall), 32'(v.exp_legal));
        chk("accept_busreq", 32'(BusReq), 32'd0);
        if (!v.exp_legal) begin
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
            chk("illegal_err", 32'(Err), 32'(v.exp_cause != 2'b00));
            chk("illegal_busreq", 32'(BusReq), 32'd0);
            if (v.exp_cause != 2'b00) begin
                chk("illegal_cause", 32'(ErrCause), 32'(v.exp_cause));
                chk("illegal_erraddr", ErrAddr, v.addr);
            end
            @(posedge clk); #1;
            @(negedge clk);
            chk("illegal_err_pulse", 32'(Err), 32'd0);
        end else begin
            timed_out = (v.waits >= TMO);
            n = timed_out ? TMO : v.waits + 1;
            for (int i = 0; i < n; i++) begin
                @(posedge clk); #1;
                BusReady = (i == v.waits);
                @(negedge clk);
                chk("wait_busreq", 32'(BusReq), 32'd1);
                chk("wait_buswe", 32'(BusWe), 32'(stv));
                chk("wait_busaddr", BusAddr, v.addr & 32'hFFFF_FFFC);
                chk("wait_byteen", 32'(BusByteEn), 32'(v.exp_be));
                chk("wait_wdata", BusWdata, v.exp_wdata);
                chk("wait_stall", 32'(Stall), 32'((i != v.waits) && (i != TMO - 1)));
            end
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
            chk("done_busreq", 32'(BusReq), 32'd0);
            chk("done_stall", 32'(Stall), 32'd0);
            chk("done_err", 32'(Err), 32'(timed_out));
            if (timed_out) begin
                chk("timeout_cause", 32'(ErrCause), 32'd2);
                chk("timeout_erraddr", ErrAddr, v.addr);
            end
            chk("done_regwrite", 32'(RegWriteOut), 32'((!timed_out && ld) ? v.lt : NOREGWRITE));
            if (!timed_out && ld) begin
                chk("done_rdata", RdataOut, v.rdata);
                chk("done_lbs", 32'(LoadedBytesSelect), 32'(v.addr[1:0]));
            end
            @(posedge clk); #1;
            @(negedge clk);
            chk("after_regwrite", 32'(RegWriteOut), 32'(NOREGWRITE));
            chk("after_err", 32'(Err), 32'd0);
        end
    endtask

    initial begin
        vec_t tbl[12];
        vec_t v;
        logic [31:0] tmp;

        tbl[0]  = '{LW,         2'b00, 32'h100, 32'h0,        0, 32'hDEADBEEF, 1'b1, 2'b00, 4'b0000, 32'h0};
        tbl[1]  = '{NOREGWRITE, 2'b01, 32'h203, 32'h12345678, 3, 32'h0,        1'b1, 2'b00, 4'b1000, 32'h78787878};
        tbl[2]  = '{NOREGWRITE, 2'b10, 32'h302, 32'h12345678, 0, 32'h0,        1'b1, 2'b00, 4'b1100, 32'h56785678};
        tbl[3]  = '{LH,         2'b00, 32'h301, 32'h0,        0, 32'h0,        1'b0, 2'b01, 4'b0000, 32'h0};
        tbl[4]  = '{LB,         2'b11, 32'h100, 32'h0,        0, 32'h0,        1'b0, 2'b11, 4'b0000, 32'h0};
        tbl[5]  = '{NOREGWRITE, 2'b11, 32'h44,  32'hCAFEBABE, 9, 32'h0,        1'b1, 2'b00, 4'b1111, 32'hCAFEBABE};
        tbl[6]  = '{LBU,        2'b00, 32'h401, 32'h0,        1, 32'hA5B6C7D8, 1'b1, 2'b00, 4'b0000, 32'h0};
        tbl[7]  = '{LHU,        2'b00, 32'h002, 32'h0,        2, 32'h13579BDF, 1'b1, 2'b00, 4'b0000, 32'h0};
        tbl[8]  = '{LW,         2'b00, 32'h002, 32'h0,        0, 32'h0,        1'b0, 2'b01, 4'b0000, 32'h0};
        tbl[9]  = '{NOREGWRITE, 2'b10, 32'h001, 32'h0,        0, 32'h0,        1'b0, 2'b01, 4'b0000, 32'h0};
        tbl[10] = '{NOREGWRITE, 2'b01, 32'h000, 32'h000000AB, 0, 32'h0,        1'b1, 2'b00, 4'b0001, 32'hABABABAB};
        tbl[11] = '{NOREGWRITE, 2'b00, 32'h123, 32'h0,        0, 32'h0,        1'b0, 2'b00, 4'b0000, 32'h0};

        rst = 1'b1; Addr = 32'd0; StoreData = 32'd0; BusRdata = 32'd0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_busreq", 32'(BusReq), 32'd0);
        chk("rst_buswe", 32'(BusWe), 32'd0);
        chk("rst_busaddr", BusAddr, 32'd0);
        chk("rst_wdata", BusWdata, 32'd0);
        chk("rst_byteen", 32'(BusByteEn), 32'd0);
        chk("rst_rdata", RdataOut, 32'd0);
        chk("rst_lbs", 32'(LoadedBytesSelect), 32'd0);
        chk("rst_regwrite", 32'(RegWriteOut), 32'(NOREGWRITE));
        chk("rst_err", 32'(Err), 32'd0);
        chk("rst_cause", 32'(ErrCause), 32'd0);
        chk("rst_erraddr", ErrAddr, 32'd0);
        chk("rst_stall", 32'(Stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_access(tbl[i]);

        // BusReady while idle must not produce a result.
        @(posedge clk); #1;
        BusReady = 1'b1; BusRdata = 32'h55555555;
        @(negedge clk);
        chk("idle_ready_stall", 32'(Stall), 32'd0);
        @(posedge clk); #1;
        BusReady = 1'b0;
        @(negedge clk);
        chk("idle_ready_regwrite", 32'(RegWriteOut), 32'(NOREGWRITE));
        chk("idle_ready_busreq", 32'(BusReq), 32'd0);

        // Back-to-back: a new request in the cycle after completion is accepted.
        @(posedge clk); #1;
        ReqValid = 1'b1; LoadType = LW; StoreType = 2'b00; Addr = 32'h10;
        @(negedge clk);
        chk("b2b_stall1", 32'(Stall), 32'd1);
        @(posedge clk); #1;
        BusReady = 1'b1; BusRdata = 32'h0BADF00D;
        @(negedge clk);
        chk("b2b_stall2", 32'(Stall), 32'd0);
        @(posedge clk); #1;
        BusReady = 1'b0; LoadType = NOREGWRITE; StoreType = 2'b11;
        Addr = 32'h20; StoreData = 32'hCAFEF00D;
        @(negedge clk);
        chk("b2b_accept", 32'(Stall), 32'd1);
        chk("b2b_regwrite", 32'(RegWriteOut), 32'(LW));
        chk("b2b_rdata", RdataOut, 32'h0BADF00D);
        @(posedge clk); #1;
        BusReady = 1'b1;
        @(negedge clk);
        chk("b2b_busreq", 32'(BusReq), 32'd1);
        chk("b2b_busaddr", BusAddr, 32'h20);
        chk("b2b_wdata", BusWdata, 32'hCAFEF00D);
        chk("b2b_byteen", 32'(BusByteEn), 32'hF);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("b2b_store_regwrite", 32'(RegWriteOut), 32'(NOREGWRITE));

        // Reset in the second WAIT cycle abandons the transaction silently.
        @(posedge clk); #1;
        ReqValid = 1'b1; LoadType = LW; Addr = 32'h500; BusRdata = 32'h77777777;
        @(negedge clk);
        chk("rstw_stall", 32'(Stall), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstw_busreq1", 32'(BusReq), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_stall_rst", 32'(Stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk("rstw_busreq", 32'(BusReq), 32'd0);
        chk("rstw_busaddr", BusAddr, 32'd0);
        chk("rstw_err", 32'(Err), 32'd0);
        chk("rstw_regwrite", 32'(RegWriteOut), 32'(NOREGWRITE));
        chk("rstw_rdata", RdataOut, 32'd0);
        run_access(tbl[6]);

        // Random accesses against the reference model.
        for (int i = 0; i < 60; i++) begin
            tmp     = $urandom;
            v.lt    = 3'($urandom_range(0, 5));
            v.st    = 2'($urandom_range(0, 3));
            if ((i % 3) != 0) begin
                if (tmp[0]) v.st = 2'b00;
                else        v.lt = NOREGWRITE;
            end
            v.addr  = $urandom;
            v.data  = $urandom;
            v.waits = $urandom_range(0, 5);
            v.rdata = $urandom;
            run_access(model(v));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_access.md
# data_mem_access

Memory-stage load/store access unit for the RISC-V core. It sits between the MEM pipeline stage and the data-memory bus. It turns one load or store per accepted request into a single word-aligned bus transaction with byte enables and replicated store data, stalls the pipeline until the bus responds, and registers the raw read word, byte offset and load type for the downstream load-extension/writeback stage. Misaligned, illegal and timed-out accesses are flagged, not performed.

## Interface
- TIMEOUT_CYCLES, 255: WAIT cycles with BusReady low before abort (1..65535).
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- ReqValid  in  1  MEM stage holds a memory instruction
- LoadType  in  3  shared load codes NOREGWRITE/LB/LH/LW/LBU/LHU from Parameters.v
- StoreType  in  2  00 none, 01 SB, 10 SH, 11 SW
- Addr  in  32  byte address
- StoreData  in  32  rs2 value
- BusReq  out  1  transaction request
- BusWe  out  1  1 = write
- BusAddr  out  32  {Addr[31:2],2'b00}
- BusWdata  out  32  replicated store data
- BusByteEn  out  4  write byte lanes
- BusRdata  in  32  read word, valid when BusReady
- BusReady  in  1  transaction complete this cycle
- Stall  out  1  freeze pipeline (combinational)
- RdataOut  out  32  raw read word to load extension
- LoadedBytesSelect  out  2  registered Addr[1:0]
- RegWriteOut  out  3  load code; NOREGWRITE when no load completes
- Err  out  1  one-cycle error pulse
- ErrCause  out  2  01 misaligned, 10 timeout, 11 both load and store set
- ErrAddr  out  32  faulting Addr

## Operation
- States: IDLE, WAIT.
- Access = ReqValid && (LoadType!=NOREGWRITE || StoreType!=00).
- Legal = exactly one of load/store set, and alignment holds: halfword needs Addr[0]=0; word needs Addr[1:0]=00; byte always aligned.
- IDLE: legal access -> latch Addr, op, StoreData, enter WAIT. Illegal access -> no bus traffic, no stall, stay IDLE. Err=1 next cycle with ErrCause and ErrAddr.
- WAIT: BusReq=1, BusAddr/BusWe/BusWdata/BusByteEn from latched values. These are stable until BusReady.
- Store lanes: SB ByteEn=0001<<off, Wdata={4{d[7:0]}}. SH ByteEn=0011<<off, Wdata={2{d[15:0]}}. SW ByteEn=1111, Wdata=d. For loads ByteEn=0000 and Wdata=0.
- WAIT with BusReady=1 -> return to IDLE. For a load, register RdataOut=BusRdata, LoadedBytesSelect=off and RegWriteOut=LoadType for exactly one cycle. For a store, RegWriteOut=NOREGWRITE.
- Timeout counter: cleared on entering WAIT, incremented each WAIT cycle with BusReady low. Reaching TIMEOUT_CYCLES gives IDLE, BusReq drop, Err pulse with cause 10, and RegWriteOut NOREGWRITE.
- Stall = !rst && ((IDLE && legal access) || (WAIT && !BusReady && !timeout_hit)).

## Timing
- Reset values: state IDLE, counter 0. BusReq, BusWe, BusAddr, BusWdata, BusByteEn, RdataOut, LoadedBytesSelect, Err, ErrCause and ErrAddr are all 0. RegWriteOut is NOREGWRITE.
- Legal request accepted in cycle T: Stall high in T, BusReq high from T+1.
- BusReady sampled high in cycle T+k (k≥1): Stall low in T+k and the pipeline advances at that edge. Load result is visible T+k+1 for one cycle. Minimum cost is 2 cycles per access.
- The instruction is still presented in the completion cycle but is not re-accepted, because the unit is in WAIT. A new request in the following cycle is accepted back-to-back.
- Illegal access in T: Err high in T+1 only, and Stall never asserts.
- BusReady while in IDLE is ignored.
- Timeout: after TIMEOUT_CYCLES WAIT cycles without BusReady, Stall drops in that cycle and Err is high in the next.
- rst high mid-WAIT: BusReq low and state IDLE after the edge. The in-flight transaction is abandoned, with no Err and no result.

## Test plan
- LW at 0x100, BusReady on the first WAIT cycle, BusRdata=0xDEADBEEF -> BusAddr=0x100, Stall for 1 cycle, RdataOut=0xDEADBEEF, LoadedBytesSelect=00, RegWriteOut=LW for 1 cycle.
- SB at 0x203, StoreData=0x12345678, 3 wait cycles -> BusByteEn=1000, BusWdata=0x78787878, BusAddr=0x200, Stall for 4 cycles, RegWriteOut=NOREGWRITE.
- SH at 0x302 -> ByteEn=1100, Wdata=0x56785678. LH at 0x301 -> no BusReq, Err with cause 01 and ErrAddr=0x301.
- Load and store both set -> Err with cause 11, no bus activity.
- TIMEOUT_CYCLES=4 and BusReady held low -> BusReq for 4 cycles, then Err with cause 10, Stall released, and the next request is accepted normally.
- rst asserted in the second WAIT cycle -> BusReq=0 the next cycle, all outputs at reset values, and a subsequent LBU at 0x401 completes with LoadedBytesSelect=01.
